// File: rtl/board_ctrl.sv
// Chess board controller: cursor, source/destination scan, vsync-aligned commit of piece vectors.
// Latency: 16-cycle scans, commit one cycle after vsync; no backpressure, buttons dropped while busy.
module board_ctrl #(
    parameter int         SCAN_LEN    = 16,
    parameter logic [5:0] CURSOR_INIT = 6'b100_100
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        btn_esc,
    input  logic        vsync,
    output logic [5:0]  cursor,
    output logic        sel_active,
    output logic [95:0] location_vectors_w,
    output logic [95:0] location_vectors_b,
    output logic [15:0] alive_vectors_w,
    output logic [15:0] alive_vectors_b,
    output logic        player,
    output logic        busy,
    output logic        move_done,
    output logic        reject
);

    localparam int          IW         = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [95:0] LOC_W_INIT = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] LOC_B_INIT = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    typedef enum logic [2:0] {
        IDLE,
        SRC_SCAN,
        SELECTED,
        DST_SCAN,
        COMMIT_WAIT,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cursor_q, cursor_d;
    logic [5:0]    sq_q, sq_d;
    logic [IW-1:0] scan_idx_q, scan_idx_d;
    logic [IW-1:0] sel_idx_q, sel_idx_d;
    logic [IW-1:0] cap_idx_q, cap_idx_d;
    logic          hit_q, hit_d;
    logic          cap_vld_q, cap_vld_d;
    logic          sel_active_q, sel_active_d;
    logic          player_q, player_d;
    logic          move_done_q, move_done_d;
    logic          reject_q, reject_d;
    logic [95:0]   loc_w_q, loc_w_d;
    logic [95:0]   loc_b_q, loc_b_d;
    logic [15:0]   alive_w_q, alive_w_d;
    logic [15:0]   alive_b_q, alive_b_d;

    logic [5:0]    own_loc [16];
    logic [5:0]    opp_loc [16];
    logic [15:0]   own_alive, opp_alive;
    logic          own_hit, opp_hit, scan_last;

    // "own" always means the side to move; the mover's vectors are frozen during a move.
    always_comb begin
        own_alive = player_q ? alive_b_q : alive_w_q;
        opp_alive = player_q ? alive_w_q : alive_b_q;
        for (int k = 0; k < 16; k++) begin
            own_loc[k] = player_q ? loc_b_q[6*k +: 6] : loc_w_q[6*k +: 6];
            opp_loc[k] = player_q ? loc_w_q[6*k +: 6] : loc_b_q[6*k +: 6];
        end
        own_hit   = own_alive[scan_idx_q] && (own_loc[scan_idx_q] == sq_q);
        opp_hit   = opp_alive[scan_idx_q] && (opp_loc[scan_idx_q] == sq_q);
        scan_last = (scan_idx_q == IW'(SCAN_LEN - 1));
    end

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        sq_d         = sq_q;
        scan_idx_d   = scan_idx_q;
        sel_idx_d    = sel_idx_q;
        cap_idx_d    = cap_idx_q;
        hit_d        = hit_q;
        cap_vld_d    = cap_vld_q;
        sel_active_d = sel_active_q;
        player_d     = player_q;
        move_done_d  = 1'b0;
        reject_d     = 1'b0;
        loc_w_d      = loc_w_q;
        loc_b_d      = loc_b_q;
        alive_w_d    = alive_w_q;
        alive_b_d    = alive_b_q;

        if (state_q == IDLE || state_q == SELECTED) begin
            if (btn_up) begin
                if (cursor_q[5:3] != 3'd7) cursor_d[5:3] = cursor_q[5:3] + 3'd1;
            end else if (btn_down) begin
                if (cursor_q[5:3] != 3'd0) cursor_d[5:3] = cursor_q[5:3] - 3'd1;
            end else if (btn_right) begin
                if (cursor_q[2:0] != 3'd7) cursor_d[2:0] = cursor_q[2:0] + 3'd1;
            end else if (btn_left) begin
                if (cursor_q[2:0] != 3'd0) cursor_d[2:0] = cursor_q[2:0] - 3'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (btn_enter) begin
                    sq_d       = cursor_q;
                    scan_idx_d = '0;
                    hit_d      = 1'b0;
                    state_d    = SRC_SCAN;
                end
            end
            SRC_SCAN: begin
                scan_idx_d = scan_idx_q + 1'b1;
                if (own_hit) begin
                    hit_d     = 1'b1;
                    sel_idx_d = scan_idx_q;
                end
                if (scan_last) begin
                    if (hit_q || own_hit) begin
                        sel_active_d = 1'b1;
                        state_d      = SELECTED;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            SELECTED: begin
                if (btn_esc) begin
                    sel_active_d = 1'b0;
                    state_d      = IDLE;
                end else if (btn_enter) begin
                    sq_d       = cursor_q;
                    scan_idx_d = '0;
                    hit_d      = 1'b0;
                    cap_vld_d  = 1'b0;
                    state_d    = DST_SCAN;
                end
            end
            DST_SCAN: begin
                scan_idx_d = scan_idx_q + 1'b1;
                if (own_hit) hit_d = 1'b1;
                if (opp_hit) begin
                    cap_vld_d = 1'b1;
                    cap_idx_d = scan_idx_q;
                end
                if (scan_last) begin
                    if (hit_q || own_hit) begin
                        reject_d = 1'b1;
                        state_d  = SELECTED;
                    end else begin
                        state_d = COMMIT_WAIT;
                    end
                end
            end
            COMMIT_WAIT: begin
                if (btn_esc) begin
                    sel_active_d = 1'b0;
                    state_d      = IDLE;
                end else if (vsync) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int k = 0; k < 16; k++) begin
                    if (!player_q) begin
                        if (k == int'(sel_idx_q)) loc_w_d[6*k +: 6] = sq_q;
                        if (cap_vld_q && k == int'(cap_idx_q)) alive_b_d[k] = 1'b0;
                    end else begin
                        if (k == int'(sel_idx_q)) loc_b_d[6*k +: 6] = sq_q;
                        if (cap_vld_q && k == int'(cap_idx_q)) alive_w_d[k] = 1'b0;
                    end
                end
                player_d     = ~player_q;
                sel_active_d = 1'b0;
                move_done_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            state_q      <= IDLE;
            cursor_q     <= CURSOR_INIT;
            sq_q         <= '0;
            scan_idx_q   <= '0;
            sel_idx_q    <= '0;
            cap_idx_q    <= '0;
            hit_q        <= 1'b0;
            cap_vld_q    <= 1'b0;
            sel_active_q <= 1'b0;
            player_q     <= 1'b0;
            move_done_q  <= 1'b0;
            reject_q     <= 1'b0;
            loc_w_q      <= LOC_W_INIT;
            loc_b_q      <= LOC_B_INIT;
            alive_w_q    <= 16'hFFFF;
            alive_b_q    <= 16'hFFFF;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            sq_q         <= sq_d;
            scan_idx_q   <= scan_idx_d;
            sel_idx_q    <= sel_idx_d;
            cap_idx_q    <= cap_idx_d;
            hit_q        <= hit_d;
            cap_vld_q    <= cap_vld_d;
            sel_active_q <= sel_active_d;
            player_q     <= player_d;
            move_done_q  <= move_done_d;
            reject_q     <= reject_d;
            loc_w_q      <= loc_w_d;
            loc_b_q      <= loc_b_d;
            alive_w_q    <= alive_w_d;
            alive_b_q    <= alive_b_d;
        end
    end

    assign cursor             = cursor_q;
    assign sel_active         = sel_active_q;
    assign location_vectors_w = loc_w_q;
    assign location_vectors_b = loc_b_q;
    assign alive_vectors_w    = alive_w_q;
    assign alive_vectors_b    = alive_b_q;
    assign player             = player_q;
    assign busy               = (state_q == SRC_SCAN) || (state_q == DST_SCAN) ||
                                (state_q == COMMIT_WAIT) || (state_q == COMMIT);
    assign move_done          = move_done_q;
    assign reject             = reject_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: cursor saturation/priority, select/move/capture, rejects,
// vsync hold, esc abort and reset during a scan, all against hand-derived board values.
module tb_board_ctrl;

    localparam logic [95:0] LOC_W_INIT = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] LOC_B_INIT = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    localparam logic [5:0] B_UP    = 6'b100000;
    localparam logic [5:0] B_DOWN  = 6'b010000;
    localparam logic [5:0] B_RIGHT = 6'b001000;
    localparam logic [5:0] B_LEFT  = 6'b000100;
    localparam logic [5:0] B_ENTER = 6'b000010;
    localparam logic [5:0] B_ESC   = 6'b000001;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_enter = 1'b0, btn_esc = 1'b0;
    logic        vsync = 1'b0;
    logic [5:0]  cursor;
    logic        sel_active, player, busy, move_done, reject;
    logic [95:0] location_vectors_w, location_vectors_b;
    logic [15:0] alive_vectors_w, alive_vectors_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [95:0] exp_w, exp_b;
    int          ncyc;

    board_ctrl dut (
        .clk12              (clk12),
        .reset              (reset),
        .btn_up             (btn_up),
        .btn_down           (btn_down),
        .btn_left           (btn_left),
        .btn_right          (btn_right),
        .btn_enter          (btn_enter),
        .btn_esc            (btn_esc),
        .vsync              (vsync),
        .cursor             (cursor),
        .sel_active         (sel_active),
        .location_vectors_w (location_vectors_w),
        .location_vectors_b (location_vectors_b),
        .alive_vectors_w    (alive_vectors_w),
        .alive_vectors_b    (alive_vectors_b),
        .player             (player),
        .busy               (busy),
        .move_done          (move_done),
        .reject             (reject)
    );

    always #5 clk12 = ~clk12;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic pulse(input logic [5:0] b);
        {btn_up, btn_down, btn_right, btn_left, btn_enter, btn_esc} = b;
        tick();
        {btn_up, btn_down, btn_right, btn_left, btn_enter, btn_esc} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic goto_sq(input logic [5:0] tgt);
        for (int i = 0; i < 20; i++) begin
            if (cursor[5:3] < tgt[5:3])      pulse(B_UP);
            else if (cursor[5:3] > tgt[5:3]) pulse(B_DOWN);
            else if (cursor[2:0] < tgt[2:0]) pulse(B_RIGHT);
            else if (cursor[2:0] > tgt[2:0]) pulse(B_LEFT);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".cursor"},  96'(cursor), 96'(6'o44));
        check({tag, ".sel"},     96'(sel_active), 96'(0));
        check({tag, ".player"},  96'(player), 96'(0));
        check({tag, ".busy"},    96'(busy), 96'(0));
        check({tag, ".done"},    96'(move_done), 96'(0));
        check({tag, ".reject"},  96'(reject), 96'(0));
        check({tag, ".alive_w"}, 96'(alive_vectors_w), 96'(16'hFFFF));
        check({tag, ".alive_b"}, 96'(alive_vectors_b), 96'(16'hFFFF));
        check({tag, ".loc_w"},   location_vectors_w, LOC_W_INIT);
        check({tag, ".loc_b"},   location_vectors_b, LOC_B_INIT);
    endtask

    initial begin
        do_reset();
        check_reset_state("rst");

        // cursor saturation and button priority
        pulse(B_LEFT);
        check("cur_first_left", 96'(cursor), 96'(6'o43));
        repeat (4) pulse(B_LEFT);
        repeat (5) pulse(B_DOWN);
        check("cur_corner", 96'(cursor), 96'(6'o00));
        repeat (3) tick();
        check("cur_hold", 96'(cursor), 96'(6'o00));
        repeat (9) pulse(B_UP);
        check("cur_top", 96'(cursor), 96'(6'o70));
        pulse(B_DOWN | B_RIGHT | B_LEFT);
        check("cur_prio_down", 96'(cursor), 96'(6'o60));
        pulse(B_RIGHT | B_LEFT);
        check("cur_prio_right", 96'(cursor), 96'(6'o61));

        // white pawn o14 -> o34
        do_reset();
        goto_sq(6'o14);
        pulse(B_ENTER);
        check("src_busy", 96'(busy), 96'(1));
        wait_idle(ncyc);
        check("src_cycles", 96'(ncyc), 96'(16));
        check("src_sel", 96'(sel_active), 96'(1));
        check("src_noreject", 96'(reject), 96'(0));
        goto_sq(6'o34);
        check("sel_cursor", 96'(cursor), 96'(6'o34));
        pulse(B_ENTER);
        repeat (20) tick();
        check("cw_busy", 96'(busy), 96'(1));
        check("cw_loc_w", location_vectors_w, LOC_W_INIT);
        vsync_pulse();
        exp_w = LOC_W_INIT;
        exp_w[71:66] = 6'o34;
        check("mv1_done", 96'(move_done), 96'(1));
        check("mv1_loc_w", location_vectors_w, exp_w);
        check("mv1_player", 96'(player), 96'(1));
        check("mv1_sel", 96'(sel_active), 96'(0));
        tick();
        check("mv1_done_once", 96'(move_done), 96'(0));

        // black queen o73 captures the pawn on o34
        goto_sq(6'o73);
        pulse(B_ENTER);
        wait_idle(ncyc);
        check("bq_sel", 96'(sel_active), 96'(1));
        goto_sq(6'o34);
        pulse(B_ENTER);
        repeat (20) tick();
        vsync_pulse();
        exp_b = LOC_B_INIT;
        exp_b[11:6] = 6'o34;
        check("mv2_done", 96'(move_done), 96'(1));
        check("mv2_loc_b", location_vectors_b, exp_b);
        check("mv2_loc_w", location_vectors_w, exp_w);
        check("mv2_alive_w", 96'(alive_vectors_w), 96'(16'hF7FF));
        check("mv2_alive_b", 96'(alive_vectors_b), 96'(16'hFFFF));
        check("mv2_player", 96'(player), 96'(0));

        // reset in the middle of a destination scan
        goto_sq(6'o13);
        pulse(B_ENTER);
        wait_idle(ncyc);
        check("p12_sel", 96'(sel_active), 96'(1));
        goto_sq(6'o23);
        pulse(B_ENTER);
        repeat (5) tick();
        check("mid_dst_busy", 96'(busy), 96'(1));
        reset = 1'b1;
        tick();
        check_reset_state("rst_dst");
        reset = 1'b0;
        tick();
        check("rst_dst_after", 96'(busy), 96'(0));

        // rejects: empty source, own-piece destination
        do_reset();
        goto_sq(6'o30);
        pulse(B_ENTER);
        wait_idle(ncyc);
        check("empty_cycles", 96'(ncyc), 96'(16));
        check("empty_reject", 96'(reject), 96'(1));
        check("empty_sel", 96'(sel_active), 96'(0));
        tick();
        check("empty_reject_once", 96'(reject), 96'(0));
        goto_sq(6'o04);
        pulse(B_ENTER);
        wait_idle(ncyc);
        check("king_sel", 96'(sel_active), 96'(1));
        goto_sq(6'o03);
        pulse(B_ENTER);
        wait_idle(ncyc);
        check("own_reject", 96'(reject), 96'(1));
        check("own_sel_kept", 96'(sel_active), 96'(1));
        check("own_loc_w", location_vectors_w, LOC_W_INIT);
        pulse(B_ESC);
        check("esc_sel", 96'(sel_active), 96'(0));
        check("esc_busy", 96'(busy), 96'(0));

        // vsync held low: board frozen, buttons ignored, esc aborts
        do_reset();
        goto_sq(6'o14);
        pulse(B_ENTER);
        wait_idle(ncyc);
        goto_sq(6'o24);
        pulse(B_ENTER);
        repeat (20) tick();
        pulse(B_UP);
        check("cw_cursor_frozen", 96'(cursor), 96'(6'o24));
        for (int i = 0; i < 10; i++) begin
            repeat (100) tick();
            check("cw_hold_loc_w", location_vectors_w, LOC_W_INIT);
        end
        check("cw_hold_busy", 96'(busy), 96'(1));
        check("cw_hold_player", 96'(player), 96'(0));
        pulse(B_ESC);
        check("abort_busy", 96'(busy), 96'(0));
        check("abort_sel", 96'(sel_active), 96'(0));
        check("abort_player", 96'(player), 96'(0));
        check("abort_done", 96'(move_done), 96'(0));
        vsync_pulse();
        check("abort_loc_w", location_vectors_w, LOC_W_INIT);
        check("abort_player2", 96'(player), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 SHALL have parameter SCAN_LEN, 16, pieces per colour scanned per square lookup.
REQ-002 SHALL have parameter CURSOR_INIT, 6'b100_100, cursor reset value as {row,col}.
REQ-003 SHALL have port clk12  input  1  system clock; reset is synchronous to clk12, active-high.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_up, btn_down, btn_left, btn_right  input  1 each  debounced single-cycle cursor pulses.
REQ-006 SHALL have port btn_enter, btn_esc  input  1 each  debounced single-cycle select/cancel pulses.
REQ-007 SHALL have port vsync  input  1  display vertical sync, active-high.
REQ-008 SHALL have port cursor  output  6  {row[5:3],col[2:0]}; row 0 is white's back rank.
REQ-009 SHALL have port sel_active  output  1  source piece latched; drives the display's selection highlight.
REQ-010 SHALL have port location_vectors_w, location_vectors_b  output  96 each  piece k at bits [6k+5:6k] as {row,col}; k=0 king, 1 queen, 2-3 bishops, 4-5 knights, 6-7 rooks, 8-15 pawns.
REQ-011 SHALL have port alive_vectors_w, alive_vectors_b  output  16 each  bit k=1 means piece k is on the board.
REQ-012 SHALL have port player  output  1  side to move, 0=white, 1=black.
REQ-013 SHALL have port busy  output  1  high in SRC_SCAN, DST_SCAN, COMMIT_WAIT, COMMIT.
REQ-014 SHALL have port move_done, reject  output  1 each  single-cycle status pulses.

Function
REQ-015 SHALL implement states IDLE, SRC_SCAN, SELECTED, DST_SCAN, COMMIT_WAIT, COMMIT.
REQ-016 SHALL move the cursor only in IDLE/SELECTED, one step per cycle, registered one cycle after the pulse: up row+1, down row-1, right col+1, left col-1, each saturating at 0/7.
REQ-017 SHALL apply one move per cycle on simultaneous presses, priority up>down>right>left, others dropped.
REQ-018 SHALL, on btn_enter in IDLE, latch the cursor and enter SRC_SCAN, scanning index 0..15 of the mover's vectors one per cycle for an alive piece at the latched square.
REQ-019 SHALL, after 16 scan cycles, go to SELECTED with sel_idx latched and sel_active=1 on a hit, else return to IDLE with a one-cycle reject pulse.
REQ-020 SHALL, on btn_esc in SELECTED, return to IDLE and clear sel_active the next cycle.
REQ-021 SHALL, on btn_enter in SELECTED, latch the destination and run DST_SCAN for 16 cycles, checking own and opponent vectors in parallel at each index.
REQ-022 SHALL, if the destination holds an alive own piece (including the source square), pulse reject and return to SELECTED with the selection kept; otherwise record the capture index if an alive opponent piece matched, then enter COMMIT_WAIT.
REQ-023 SHALL hold vectors and player stable from COMMIT_WAIT entry until vsync=1 is sampled, then enter COMMIT for exactly one cycle.
REQ-024 SHALL, in COMMIT, write the destination into the mover's sel_idx field, clear the captured piece's alive bit, toggle player, clear sel_active, pulse move_done, and go to IDLE.
REQ-025 SHALL make COMMIT updates visible on the cycle after COMMIT, with move_done coincident.
REQ-026 SHALL abort to IDLE on btn_esc in COMMIT_WAIT with no state change and sel_active cleared; btn_esc in the scan states SHALL be ignored.
REQ-027 SHALL ignore all buttons while busy, except btn_esc in COMMIT_WAIT.
REQ-028 SHALL NOT check move legality; any non-own destination is accepted.

Reset
REQ-029 SHALL, on reset, set state IDLE, cursor=CURSOR_INIT, sel_active=0, player=0, busy=0, move_done=0, reject=0, alive_vectors_w/b=16'hFFFF.
REQ-030 SHALL, on reset, set location_vectors_w=96'h20928B30D38F0070460850C4 and location_vectors_b=96'hC31CB3D35DB7E3FE7EEBDEFC.
REQ-031 SHALL let reset override any state, including mid-scan and COMMIT_WAIT, with no partial update retained.

Verification
REQ-032 SHALL verify: reset, then 5 left pulses and 5 down pulses -> cursor=6'o00 and holds; 9 up pulses -> cursor=6'o70.
REQ-033 SHALL verify: cursor 6'o14, enter -> busy 16 cycles, sel_active=1; cursor 6'o34, enter, vsync pulse -> location_vectors_w[71:66]=6'o34, player=1, move_done one cycle.
REQ-034 SHALL verify: after REQ-033, black selects 6'o73 (queen), enters at 6'o34, vsync -> location_vectors_b[11:6]=6'o34, alive_vectors_w[11]=0, player=0.
REQ-035 SHALL verify: IDLE enter at empty 6'o30 -> reject pulse, sel_active=0; select 6'o04, enter at 6'o03 -> reject, still SELECTED.
REQ-036 SHALL verify: with vsync held low in COMMIT_WAIT, vectors unchanged for 1000 cycles; esc -> IDLE with player unchanged.
REQ-037 SHALL verify: reset asserted during DST_SCAN -> all outputs equal the REQ-029/REQ-030 values on the next cycle.
